// File: rtl/gcd_pkg.sv
// Shared definitions for the binary GCD unit: FSM state encoding and default operand width.
package gcd_pkg;

    localparam int GCD_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gcdState_t;

endpackage : gcd_pkg

// File: rtl/gcd_step.sv
// One Stein (binary GCD) reduction step: given the working pair and the common
// power-of-two count, produce the next pair, the next count and an equality flag.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_DEFAULT_WIDTH,
    parameter int KW    = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] curA,
    input  logic [WIDTH-1:0] curB,
    input  logic [KW-1:0]    curK,
    output logic [WIDTH-1:0] nextA,
    output logic [WIDTH-1:0] nextB,
    output logic [KW-1:0]    nextK,
    output logic             isEqual
);

    logic aEven;
    logic bEven;
    logic aLarger;

    assign aEven   = ~curA[0];
    assign bEven   = ~curB[0];
    assign aLarger = (curA > curB);

    always_comb begin
        nextA   = curA;
        nextB   = curB;
        nextK   = curK;
        isEqual = (curA == curB);
        if (!isEqual) begin
            if (aEven && bEven) begin
                nextA = curA >> 1;
                nextB = curB >> 1;
                nextK = curK + KW'(1);
            end else if (aEven) begin
                nextA = curA >> 1;
            end else if (bEven) begin
                nextB = curB >> 1;
            end else if (aLarger) begin
                // Difference of two odds is even, so the shift drops no information.
                nextA = (curA - curB) >> 1;
            end else begin
                nextB = (curB - curA) >> 1;
            end
        end
    end

endmodule : gcd_step

// File: rtl/binary_gcd_unit.sv
// Iterative binary GCD with valid/ready handshakes on both sides.
// Optional feature macro: GCD_COPRIME_FLAG_EN adds the coprime output.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// RUN   | one reduction step per cycle until A==B
// DONE  | result held on gcd, out_valid=1 until out_ready
module binary_gcd_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_DEFAULT_WIDTH,
    parameter int KW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef GCD_COPRIME_FLAG_EN
    output logic             coprime,
`endif
    output logic [WIDTH-1:0] gcd
);

    gcdState_t        state;
    logic [WIDTH-1:0] regA;
    logic [WIDTH-1:0] regB;
    logic [KW-1:0]    regK;
    logic [WIDTH-1:0] gcdReg;
    logic             outValidReg;
    logic             inReadyReg;

    logic [WIDTH-1:0] nextA;
    logic [WIDTH-1:0] nextB;
    logic [KW-1:0]    nextK;
    logic             isEqual;

    gcd_step #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) stepInst (
        .curA    (regA),
        .curB    (regB),
        .curK    (regK),
        .nextA   (nextA),
        .nextB   (nextB),
        .nextK   (nextK),
        .isEqual (isEqual)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            regA        <= '0;
            regB        <= '0;
            regK        <= '0;
            gcdReg      <= '0;
            outValidReg <= 1'b0;
            inReadyReg  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        regA       <= a;
                        regB       <= b;
                        regK       <= '0;
                        inReadyReg <= 1'b0;
                        if ((a == '0) || (b == '0)) begin
                            gcdReg      <= a | b;
                            outValidReg <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (isEqual) begin
                        // Result never exceeds min(a,b), so the shift cannot overflow.
                        gcdReg      <= regA << regK;
                        outValidReg <= 1'b1;
                        state       <= DONE;
                    end else begin
                        regA <= nextA;
                        regB <= nextB;
                        regK <= nextK;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValidReg <= 1'b0;
                        inReadyReg  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    outValidReg <= 1'b0;
                    inReadyReg  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = inReadyReg;
    assign out_valid = outValidReg;
    assign gcd       = gcdReg;

`ifdef GCD_COPRIME_FLAG_EN
    assign coprime = outValidReg && (gcdReg == WIDTH'(1));
`endif

endmodule : binary_gcd_unit

// File: tb/tb_binary_gcd_unit.sv
// Self-checking bench for binary_gcd_unit: directed scenarios plus random pairs
// compared against a Euclid (modulo) reference model.
module tb_binary_gcd_unit;

    localparam int WIDTH  = 32;
    localparam int MAXLAT = 2 * WIDTH + 1;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] gcd;
`ifdef GCD_COPRIME_FLAG_EN
    logic             coprime;
`endif

    int testsRun;
    int testsFailed;

    binary_gcd_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef GCD_COPRIME_FLAG_EN
        .coprime   (coprime),
`endif
        .gcd       (gcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] refGcd(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] t;
        p = x;
        q = y;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Presents a pair, waits for the result (bounded) and completes the handshake.
    // lat counts rising edges after the accept edge until out_valid is seen.
    task automatic runPair(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           output logic [WIDTH-1:0] res, output int lat,
                           output logic cpFlag, output logic gotIt);
        a        = x;
        b        = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 0;
        while (!out_valid && lat < MAXLAT + 4) begin
            tick();
            lat++;
        end
        gotIt  = out_valid;
        res    = gcd;
`ifdef GCD_COPRIME_FLAG_EN
        cpFlag = coprime;
`else
        cpFlag = 1'b0;
`endif
        if (gotIt) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end else begin
            pulseReset();
        end
    endtask

    task automatic checkPair(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                             input int latLimit);
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] expGcd;
        int               lat;
        logic             cp;
        logic             got;
        expGcd = refGcd(x, y);
        runPair(x, y, res, lat, cp, got);
        checkVal({tag, "_done"}, 64'(got), 64'(1));
        checkVal({tag, "_gcd"}, 64'(res), 64'(expGcd));
        checkVal({tag, "_lat"}, 64'(lat <= latLimit), 64'(1));
`ifdef GCD_COPRIME_FLAG_EN
        checkVal({tag, "_coprime"}, 64'(cp), 64'(expGcd == 1));
`else
        checkVal({tag, "_coprime"}, 64'(cp), 64'(0));
`endif
    endtask

    initial begin
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] heldGcd;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        int               lat;
        int               waitCnt;
        logic             cp;
        logic             got;

        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a           = '0;
        b           = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        checkVal("rst_in_ready", 64'(in_ready), 64'(1));
        checkVal("rst_out_valid", 64'(out_valid), 64'(0));
        checkVal("rst_gcd", 64'(gcd), 64'(0));

        checkPair("p48_18", 48, 18, 65);

        runPair(6, 6, res, lat, cp, got);
        checkVal("eq_gcd", 64'(res), 64'(6));
        checkVal("eq_lat", 64'(lat), 64'(1));
        runPair(0, 7, res, lat, cp, got);
        checkVal("zero_b_gcd", 64'(res), 64'(7));
        checkVal("zero_b_lat", 64'(lat <= 1), 64'(1));
        runPair(0, 0, res, lat, cp, got);
        checkVal("zero_zero_gcd", 64'(res), 64'(0));
        checkVal("zero_zero_lat", 64'(lat <= 1), 64'(1));
        checkVal("zero_zero_ret", 64'(gcd), 64'(0));

        checkPair("pow2", 32'h8000_0000, 32'h4000_0000, MAXLAT);
        checkPair("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFE, MAXLAT);
        checkVal("retain_gcd", 64'(gcd), 64'(1));

        // Backpressure: result must hold while busy inputs are ignored.
        a        = 100;
        b        = 75;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        waitCnt  = 0;
        while (!out_valid && waitCnt < MAXLAT + 4) begin
            tick();
            waitCnt++;
        end
        checkVal("bp_valid", 64'(out_valid), 64'(1));
        heldGcd = gcd;
        checkVal("bp_gcd", 64'(heldGcd), 64'(25));
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a        = $urandom | 32'h1;
            b        = $urandom | 32'h1;
            tick();
            checkVal("bp_hold_valid", 64'(out_valid), 64'(1));
            checkVal("bp_hold_gcd", 64'(gcd), 64'(heldGcd));
            checkVal("bp_in_ready", 64'(in_ready), 64'(0));
        end
        a         = 21;
        b         = 14;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkVal("hs_no_accept", 64'(in_ready), 64'(1));
        checkVal("hs_valid_low", 64'(out_valid), 64'(0));
        tick();
        in_valid = 1'b0;
        checkVal("post_hs_busy", 64'(in_ready), 64'(0));
        waitCnt = 0;
        while (!out_valid && waitCnt < MAXLAT + 4) begin
            tick();
            waitCnt++;
        end
        checkVal("post_hs_gcd", 64'(gcd), 64'(7));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of a run aborts it.
        a        = 35;
        b        = 64;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkVal("abort_no_valid", 64'(out_valid), 64'(0));
            tick();
        end
        reset = 1'b1;
        #1;
        checkVal("abort_async_valid", 64'(out_valid), 64'(0));
        checkVal("abort_async_gcd", 64'(gcd), 64'(0));
        tick();
        reset = 1'b0;
        tick();
        checkVal("abort_in_ready", 64'(in_ready), 64'(1));
        checkVal("abort_out_valid", 64'(out_valid), 64'(0));
        checkPair("after_abort", 35, 64, MAXLAT);

        // Random pairs: full-width operands, then 16-bit operands with the tighter bound.
        for (int i = 0; i < 500; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 4 == 1) begin
                x = x >> $urandom_range(0, 28);
                y = y >> $urandom_range(0, 28);
            end else if (i % 4 == 2) begin
                x = (x >> 16) << $urandom_range(0, 12);
                y = (y >> 16) << $urandom_range(0, 12);
            end else if (i % 4 == 3) begin
                y = x * WIDTH'($urandom_range(1, 7)) >> $urandom_range(0, 3);
            end
            checkPair("rnd32", x, y, MAXLAT);
        end
        for (int i = 0; i < 500; i++) begin
            x = WIDTH'($urandom_range(0, 16'hFFFF));
            y = WIDTH'($urandom_range(0, 16'hFFFF));
            if (i % 3 == 0) begin
                x = x & ~WIDTH'(32'hF);
                y = y & ~WIDTH'(32'h7);
            end
            checkPair("rnd16", x, y, 2 * 16 + 1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule : tb_binary_gcd_unit
